// File: rtl/aesha3_host_pkg.sv
// Shared types and constants for the AES/SHA3 host-side initiator.
// Byte helpers pick bytes MSB-first from 128-bit fields.
package aesha3_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_KEY,
    WAIT_KEY,
    SEND_MSG,
    COLLECT,
    DONE
  } state_t;

  localparam int unsigned SALT_BYTES   = 16;
  localparam int unsigned PW_BYTES     = 16;
  localparam int unsigned MSG_BYTES    = 16;
  localparam int unsigned CIPHER_BYTES = 16;
  localparam int unsigned MAC_BYTES    = 32;

  function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [3:0] idx);
    logic [127:0] s;
    s = v << {idx, 3'b000};
    return s[127:120];
  endfunction

  // {start, data} for key-phase byte idx: salt, then pw up to len, then idle padding.
  function automatic logic [8:0] key_byte(input logic [127:0] salt, input logic [127:0] pw,
                                          input logic [4:0] len, input logic [5:0] idx);
    if (idx < 6'(SALT_BYTES))
      return {1'b1, byte_at(salt, idx[3:0])};
    else if (idx < 6'(SALT_BYTES + PW_BYTES) && {1'b0, idx[3:0]} < len)
      return {1'b1, byte_at(pw, idx[3:0])};
    else
      return 9'h000;
  endfunction

endpackage

// File: rtl/aesha3_rx_shift.sv
// Byte deserialiser: each enabled byte enters at the top, so the first
// received byte ends up at [7:0] once WIDTH/8 bytes have arrived.
module aesha3_rx_shift #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= {din, q[WIDTH-1:8]};
  end

endmodule

// File: rtl/aesha3_host_ctrl.sv
// Host-side initiator for the AES/SHA3 byte-serial engine port.
// Optional wait-state timeout: define AESHA3_HOST_TIMEOUT_EN.
module aesha3_host_ctrl
  import aesha3_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_salt,
  input  logic [127:0] cmd_pw,
  input  logic [4:0]   cmd_pw_len,
  input  logic [127:0] cmd_msg,
  input  logic         cmd_mode,
  output logic [7:0]   eng_data,
  output logic         eng_start,
  output logic         eng_mode,
  input  logic [7:0]   eng_rdata,
  input  logic         eng_rvalid,
  input  logic         eng_ien,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_cipher,
  output logic [255:0] res_mac,
  output logic         res_err
);

  state_t       state;
  logic [5:0]   cnt;
  logic [127:0] salt_r, pw_r, msg_r;
  logic [4:0]   pw_len_r;
  logic         accept, shift_c, shift_m, timeout;
  logic [8:0]   nxt_key;

  always_comb begin
    accept  = (state == IDLE) && cmd_valid;
    shift_c = (state == COLLECT) && eng_rvalid && (cnt < 6'(CIPHER_BYTES));
    shift_m = (state == COLLECT) && eng_rvalid && (cnt >= 6'(CIPHER_BYTES));
    nxt_key = key_byte(salt_r, pw_r, pw_len_r, cnt + 6'd1);
  end

  // Outputs are registered, so each state drives the byte for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      salt_r    <= '0;
      pw_r      <= '0;
      msg_r     <= '0;
      pw_len_r  <= '0;
      cmd_ready <= 1'b1;
      eng_start <= 1'b0;
      eng_data  <= '0;
      eng_mode  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          salt_r    <= cmd_salt;
          pw_r      <= cmd_pw;
          pw_len_r  <= (cmd_pw_len > 5'd16) ? 5'd16 : cmd_pw_len;
          msg_r     <= cmd_msg;
          eng_mode  <= cmd_mode;
          cnt       <= '0;
          cmd_ready <= 1'b0;
          eng_start <= 1'b1;
          eng_data  <= cmd_salt[127:120];
          state     <= SEND_KEY;
        end
        SEND_KEY: begin
          if (cnt == 6'(SALT_BYTES + PW_BYTES - 1)) begin
            eng_start <= 1'b0;
            eng_data  <= '0;
            state     <= WAIT_KEY;
          end else begin
            cnt                   <= cnt + 6'd1;
            {eng_start, eng_data} <= nxt_key;
          end
        end
        WAIT_KEY: begin
          if (!eng_ien) begin
            cnt       <= '0;
            eng_start <= 1'b1;
            eng_data  <= msg_r[127:120];
            state     <= SEND_MSG;
          end else if (timeout) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        SEND_MSG: begin
          if (cnt == 6'(MSG_BYTES - 1)) begin
            cnt       <= '0;
            eng_start <= 1'b0;
            eng_data  <= '0;
            state     <= COLLECT;
          end else begin
            cnt      <= cnt + 6'd1;
            eng_data <= byte_at(msg_r, cnt[3:0] + 4'd1);
          end
        end
        COLLECT: begin
          if (eng_rvalid)
            cnt <= cnt + 6'd1;
          if ((eng_rvalid && cnt == 6'(CIPHER_BYTES + MAC_BYTES - 1)) || timeout) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  aesha3_rx_shift #(.WIDTH(8 * CIPHER_BYTES)) u_cipher (
    .clk(clk), .rst(rst), .clr(accept), .en(shift_c), .din(eng_rdata), .q(res_cipher)
  );

  aesha3_rx_shift #(.WIDTH(8 * MAC_BYTES)) u_mac (
    .clk(clk), .rst(rst), .clr(accept), .en(shift_m), .din(eng_rdata), .q(res_mac)
  );

`ifdef AESHA3_HOST_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;

  // Both wait states are only entered from non-wait states, so clearing
  // outside them is the same as clearing on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == WAIT_KEY || state == COLLECT)
      wait_cnt <= wait_cnt + WW'(1);
    else
      wait_cnt <= '0;
  end

  always_comb
    timeout = (state == WAIT_KEY || state == COLLECT) && (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      res_err <= 1'b0;
    else if (accept)
      res_err <= 1'b0;
    else if (timeout)
      res_err <= 1'b1;
  end
`else
  always_comb timeout = 1'b0;
  always_comb res_err = 1'b0;
`endif

endmodule

// File: tb/tb_aesha3_host_ctrl.sv
// Directed self-checking bench for aesha3_host_ctrl with a scripted engine model.
module tb_aesha3_host_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [127:0] cmd_salt = '0, cmd_pw = '0, cmd_msg = '0;
  logic [4:0]   cmd_pw_len = '0;
  logic         cmd_mode = 1'b0;
  logic [7:0]   eng_data;
  logic         eng_start, eng_mode;
  logic [7:0]   eng_rdata = '0;
  logic         eng_rvalid = 1'b0;
  logic         eng_ien = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [127:0] res_cipher;
  logic [255:0] res_mac;
  logic         res_err;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] SALT   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PW8    = 128'h70617373776F72640000000000000000;
  localparam logic [127:0] PW16   = 128'h4142434445464748494A4B4C4D4E4F50;
  localparam logic [127:0] MSG    = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] CIPHER = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;
  localparam logic [255:0] MAC    =
    256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;

  always #5 clk = ~clk;

  aesha3_host_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_salt(cmd_salt), .cmd_pw(cmd_pw), .cmd_pw_len(cmd_pw_len),
    .cmd_msg(cmd_msg), .cmd_mode(cmd_mode),
    .eng_data(eng_data), .eng_start(eng_start), .eng_mode(eng_mode),
    .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid), .eng_ien(eng_ien),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_cipher(res_cipher), .res_mac(res_mac), .res_err(res_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    eng_ien = 1'b0;
    eng_rvalid = 1'b0;
    eng_rdata = '0;
    res_ready = 1'b0;
    #2;
    tick;
    rst = 1'b0;
  endtask

  task automatic issue(input logic [127:0] salt, input logic [127:0] pw, input logic [4:0] len,
                       input logic [127:0] msg, input logic mode);
    cmd_salt = salt; cmd_pw = pw; cmd_pw_len = len; cmd_msg = msg; cmd_mode = mode;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Samples the 32 key-phase cycles (first byte ends at the MSB); engine goes busy after.
  task automatic cap_key(output logic [31:0] starts, output logic [255:0] stream);
    starts = '0; stream = '0;
    for (int k = 0; k < 32; k++) begin
      starts = {starts[30:0], eng_start};
      stream = {stream[247:0], eng_data};
      if (k == 31) eng_ien = 1'b1;
      tick;
    end
  endtask

  // Engine stays busy for n cycles while spurious rvalid bytes are offered.
  task automatic hold_ien(input int n, output int starts_seen);
    starts_seen = 0;
    eng_rvalid = 1'b1;
    eng_rdata = 8'hEE;
    for (int i = 0; i < n; i++) begin
      if (eng_start) starts_seen++;
      tick;
    end
    eng_ien = 1'b0;
    eng_rvalid = 1'b0;
    tick;
  endtask

  task automatic cap_msg(output logic [15:0] starts, output logic [127:0] stream);
    starts = '0; stream = '0;
    for (int k = 0; k < 16; k++) begin
      starts = {starts[14:0], eng_start};
      stream = {stream[119:0], eng_data};
      tick;
    end
  endtask

  // Cipher bytes C0..CF with a 5-cycle gap mid-stream, then MAC bytes 00..1F.
  task automatic feed_result(output logic valid_in_gap);
    valid_in_gap = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 8) begin
        eng_rvalid = 1'b0;
        repeat (5) begin
          if (res_valid) valid_in_gap = 1'b1;
          tick;
        end
      end
      eng_rvalid = 1'b1;
      eng_rdata = (i < 16) ? 8'(8'hC0 + i) : 8'(i - 16);
      tick;
    end
    eng_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, eng_start, eng_data, eng_mode, res_valid, res_err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp %b",
               {cmd_ready, eng_start, eng_data, eng_mode, res_valid, res_err}, 13'b1_0_00000000_0_0_0);
    end
    checks++;
    if (res_cipher !== '0) begin errors++; $display("FAIL reset_cipher got %h exp 0", res_cipher); end
    checks++;
    if (res_mac !== '0) begin errors++; $display("FAIL reset_mac got %h exp 0", res_mac); end
  endtask

  task automatic test_basic_job;
    logic [31:0] ks; logic [255:0] kd; logic [15:0] ms; logic [127:0] md;
    int seen; logic gapv; int held;
    issue(SALT, PW8, 5'd8, MSG, 1'b0);
    cap_key(ks, kd);
    checks++;
    if (ks !== 32'hFFFFFF00) begin errors++; $display("FAIL key_starts got %h exp FFFFFF00", ks); end
    checks++;
    if (kd !== {SALT, 64'h70617373776F7264, 64'h0}) begin
      errors++; $display("FAIL key_bytes got %h exp %h", kd, {SALT, 64'h70617373776F7264, 64'h0});
    end
    hold_ien(3, seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL start_while_busy got %0d exp 0", seen); end
    cap_msg(ms, md);
    checks++;
    if (ms !== 16'hFFFF) begin errors++; $display("FAIL msg_starts got %h exp FFFF", ms); end
    checks++;
    if (md !== MSG) begin errors++; $display("FAIL msg_bytes got %h exp %h", md, MSG); end
    checks++;
    if (eng_start !== 1'b0) begin errors++; $display("FAIL start_after_msg got %b exp 0", eng_start); end
    feed_result(gapv);
    checks++;
    if (gapv !== 1'b0) begin errors++; $display("FAIL early_res_valid got %b exp 0", gapv); end
    checks++;
    if (res_cipher !== CIPHER) begin errors++; $display("FAIL res_cipher got %h exp %h", res_cipher, CIPHER); end
    checks++;
    if (res_mac !== MAC) begin errors++; $display("FAIL res_mac got %h exp %h", res_mac, MAC); end
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL res_err got %b exp 0", res_err); end
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) held++;
      tick;
    end
    checks++;
    if (held !== 10) begin errors++; $display("FAIL res_valid_hold got %0d exp 10", held); end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL release got valid/ready %b exp 01", {res_valid, cmd_ready});
    end
    checks++;
    if (res_cipher !== CIPHER) begin errors++; $display("FAIL cipher_stable got %h exp %h", res_cipher, CIPHER); end
  endtask

  task automatic test_pw_len(input logic [4:0] len, input logic [127:0] pw,
                             input logic [31:0] exp_starts, input logic [255:0] exp_bytes);
    logic [31:0] ks; logic [255:0] kd;
    issue(SALT, pw, len, MSG, 1'b0);
    cap_key(ks, kd);
    checks++;
    if (ks !== exp_starts) begin
      errors++; $display("FAIL pw_len%0d_starts got %h exp %h", len, ks, exp_starts);
    end
    checks++;
    if (kd !== exp_bytes) begin
      errors++; $display("FAIL pw_len%0d_bytes got %h exp %h", len, kd, exp_bytes);
    end
    do_reset;
  endtask

  task automatic test_back_to_back;
    logic [31:0] ks; logic [255:0] kd; logic [15:0] ms; logic [127:0] md;
    int seen; logic gapv;
    issue(SALT, PW8, 5'd8, MSG, 1'b1);
    // A second request is held pending for the whole first job.
    cmd_salt = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF; cmd_pw = PW16; cmd_pw_len = 5'd16;
    cmd_msg = '1; cmd_mode = 1'b0; cmd_valid = 1'b1;
    cap_key(ks, kd);
    checks++;
    if (kd !== {SALT, 64'h70617373776F7264, 64'h0}) begin
      errors++; $display("FAIL b2b_first_key got %h exp %h", kd, {SALT, 64'h70617373776F7264, 64'h0});
    end
    hold_ien(200, seen);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL long_busy_starts got %0d exp 0", seen); end
    checks++;
    if (eng_mode !== 1'b1) begin errors++; $display("FAIL eng_mode got %b exp 1", eng_mode); end
    cap_msg(ms, md);
    checks++;
    if ({ms, md} !== {16'hFFFF, MSG}) begin
      errors++; $display("FAIL long_busy_msg got %h exp %h", {ms, md}, {16'hFFFF, MSG});
    end
    feed_result(gapv);
    repeat (3) tick;
    checks++;
    if ({res_valid, cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL b2b_blocked got valid/ready %b exp 10", {res_valid, cmd_ready});
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", cmd_ready); end
    tick;
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, eng_start, eng_data, eng_mode} !== {1'b0, 1'b1, 8'hF0, 1'b0}) begin
      errors++; $display("FAIL b2b_second_accept got %h exp %h",
                         {cmd_ready, eng_start, eng_data, eng_mode}, {1'b0, 1'b1, 8'hF0, 1'b0});
    end
    cap_key(ks, kd);
    checks++;
    if ({ks, kd} !== {32'hFFFFFFFF, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, PW16}) begin
      errors++; $display("FAIL b2b_second_key got %h", {ks, kd});
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    hold_ien(1, seen);
    tick;
    tick;
    checks++;
    if (eng_start !== 1'b1) begin errors++; $display("FAIL in_send_msg got %b exp 1", eng_start); end
    rst = 1'b1;
    #1;
    checks++;
    if ({eng_start, cmd_ready, res_valid} !== 3'b010) begin
      errors++; $display("FAIL async_reset got %b exp 010", {eng_start, cmd_ready, res_valid});
    end
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if ({eng_start, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL after_reset got %b exp 01", {eng_start, cmd_ready});
    end
  endtask

`ifdef AESHA3_HOST_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] ks; logic [255:0] kd; int n;
    issue(SALT, PW8, 5'd8, MSG, 1'b0);
    cap_key(ks, kd);
    n = 0;
    while (!res_valid && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL timeout_cycles got %0d exp 64", n); end
    checks++;
    if (res_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", res_err); end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    eng_ien = 1'b0;
    issue(SALT, PW8, 5'd8, MSG, 1'b0);
    checks++;
    if (res_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", res_err); end
    do_reset;
  endtask
`endif

  initial begin
    do_reset;
    test_reset;
    test_basic_job;
    test_pw_len(5'd16, PW16, 32'hFFFFFFFF, {SALT, PW16});
    test_pw_len(5'd0,  PW16, 32'hFFFF0000, {SALT, 128'h0});
    test_pw_len(5'd20, PW16, 32'hFFFFFFFF, {SALT, PW16});
    test_back_to_back;
    test_reset_mid;
`ifdef AESHA3_HOST_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
